// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions for the transmit and receive paths
// Purpose: state encoding and default frame geometry shared by uart_tx and
//          the receiver. No ports.

package uart_pkg;

  // Default frame geometry: 8 data bits, 16x oversampling, 1 stop bit.
  localparam int DBIT_DEF    = 8;
  localparam int OS_DEF      = 16;
  localparam int SB_TICK_DEF = 16;

  // 3-bit state encodings, fixed so both directions decode identically.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP
  } uart_state_t;

endpackage

// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - request/status handshake between a byte source and uart_tx
// Purpose: bundles the per-byte request and the transmitter status.
// Signals: tx_start (request), din (byte to send), tx_busy (frame in flight),
//          tx_done_tick (one-clk pulse at end of stop period).
// Modports: master = byte source, slave = uart_tx.

interface uart_tx_if #(
  parameter int DBIT = 8
);
  logic            tx_start;
  logic [DBIT-1:0] din;
  logic            tx_busy;
  logic            tx_done_tick;

  modport master (output tx_start, output din, input tx_busy, input tx_done_tick);
  modport slave  (input tx_start, input din, output tx_busy, output tx_done_tick);
endinterface

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - oversampled UART transmitter, one byte per request
// Purpose: serialises bus.din as start bit, DBIT data bits LSB first,
//          optional even parity bit, and a stop period of SB_TICK s_ticks.
// Ports:   clk          system clock, rising edge
//          rst_n        asynchronous active-low reset
//          s_tick       one-clk oversampling enable from the baud tick counter
//          tx           registered serial line, idle high
//          bus (slave)  tx_start / din in, tx_busy / tx_done_tick out
// Build option: define UART_TX_PARITY_EN to insert an even parity bit.

module uart_tx
  import uart_pkg::*;
#(
  parameter int DBIT    = DBIT_DEF,
  parameter int SB_TICK = SB_TICK_DEF,
  parameter int OS      = OS_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s_tick,
  output logic       tx,
  uart_tx_if.slave   bus
);

  localparam int TMAX = (OS > SB_TICK) ? OS : SB_TICK;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int BW   = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [TW-1:0] OS_LAST  = TW'(OS - 1);
  localparam logic [TW-1:0] SB_LAST  = TW'(SB_TICK - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DBIT - 1);

  uart_state_t     state;
  logic [TW-1:0]   tick_cnt;
  logic [BW-1:0]   bit_cnt;
  logic [DBIT-1:0] shreg;
  logic [DBIT-1:0] shreg_nxt;
  logic            busy_q;
  logic            done_q;
`ifdef UART_TX_PARITY_EN
  logic            parity_q;
`endif

  assign shreg_nxt        = shreg >> 1;
  assign bus.tx_busy      = busy_q;
  assign bus.tx_done_tick = done_q;

  // tx is always loaded one clk ahead with the level of the state being
  // entered, so the line comes straight from a flop and never glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      tx       <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          // The done clk still belongs to the finished frame: a request
          // seen during it waits one more clk, giving a 1-clk idle gap.
          if (bus.tx_start && !done_q) begin
            state    <= START;
            shreg    <= bus.din;
            tick_cnt <= '0;
            busy_q   <= 1'b1;
            tx       <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= ^bus.din;
`endif
          end
        end
        START: begin
          if (s_tick) begin
            if (tick_cnt == OS_LAST) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              state    <= DATA;
              tx       <= shreg[0];
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (tick_cnt == OS_LAST) begin
              tick_cnt <= '0;
              shreg    <= shreg_nxt;
              if (bit_cnt == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                state <= PARITY;
                tx    <= parity_q;
`else
                state <= STOP;
                tx    <= 1'b1;
`endif
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
                tx      <= shreg_nxt[0];
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (s_tick) begin
            if (tick_cnt == OS_LAST) begin
              tick_cnt <= '0;
              state    <= STOP;
              tx       <= 1'b1;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
`endif
        STOP: begin
          if (s_tick) begin
            if (tick_cnt == SB_LAST) begin
              tick_cnt <= '0;
              state    <= IDLE;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              tx       <= 1'b1;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          tx     <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed self-checking bench for uart_tx
// Purpose: drives byte requests with s_tick every 10 clk (160 clk per bit),
//          samples tx mid-bit and compares against hand-computed frames.
// Build option: define UART_TX_PARITY_EN to exercise the parity bit.

module tb_uart_tx;

  localparam int DBIT    = 8;
  localparam int OS      = 16;
  localparam int SB_TICK = 16;

  // Frames packed with the first bit on the line (start) at bit 0.
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
  localparam logic [15:0] F_A5 = 16'b00000_10101001010;
  localparam logic [15:0] F_00 = 16'b00000_10000000000;
  localparam logic [15:0] F_55 = 16'b00000_10010101010;
  localparam logic [15:0] F_C3 = 16'b00000_10110000110;
  localparam logic [15:0] F_5A = 16'b00000_10010110100;
  localparam logic [15:0] F_07 = 16'b00000_11000001110;
`else
  localparam int NBITS = 10;
  localparam logic [15:0] F_A5 = 16'b000000_1101001010;
  localparam logic [15:0] F_00 = 16'b000000_1000000000;
  localparam logic [15:0] F_55 = 16'b000000_1010101010;
  localparam logic [15:0] F_C3 = 16'b000000_1110000110;
  localparam logic [15:0] F_5A = 16'b000000_1010110100;
`endif

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic s_tick = 1'b0;
  logic stall  = 1'b0;
  logic tx;

  int n_cmp        = 0;
  int n_bad        = 0;
  int done_cnt     = 0;
  int done_run     = 0;
  int done_run_max = 0;

  logic [15:0] fr;

  uart_tx_if #(.DBIT(DBIT)) bus ();

  uart_tx #(.DBIT(DBIT), .SB_TICK(SB_TICK), .OS(OS)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .s_tick (s_tick),
    .tx     (tx),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Free-running divide-by-10; stall only masks the pulse so tick phase is kept.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      cnt    = (cnt == 9) ? 0 : cnt + 1;
      s_tick = (cnt == 9) && !stall;
    end
  end

  always @(negedge clk) begin
    if (bus.tx_done_tick === 1'b1) begin
      done_cnt = done_cnt + 1;
      done_run = done_run + 1;
      if (done_run > done_run_max) done_run_max = done_run;
    end else begin
      done_run = 0;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_mon();
    #1;
    done_cnt     = 0;
    done_run_max = 0;
  endtask

  // Pulse tx_start for one clk; afterwards the start edge must already be on tx.
  task automatic start_frame(input logic [7:0] d);
    @(negedge clk);
    bus.din      = d;
    bus.tx_start = 1'b1;
    @(negedge clk);
    bus.tx_start = 1'b0;
    check("start_edge_tx", tx, 1'b0);
    check("start_edge_busy", bus.tx_busy, 1'b1);
  endtask

  // Called at the first negedge after tx fell; samples each bit mid-period.
  // poke_at: issue a rejected request during that bit. stall_at: mask
  // s_tick for 1000 clk during that bit and expect tx to hold exp[bit].
  task automatic capture(input int poke_at, input int stall_at,
                         input logic [15:0] exp, output logic [15:0] frame);
    frame = '0;
    wait_clk(80);
    for (int i = 0; i < NBITS; i++) begin
      frame[i] = tx;
      if (i == poke_at) begin
        bus.din      = 8'hFF;
        bus.tx_start = 1'b1;
        @(negedge clk);
        bus.tx_start = 1'b0;
        wait_clk(159);
      end else if (i == stall_at) begin
        #2 stall = 1'b1;
        wait_clk(500);
        check("stall_hold_mid", tx, exp[i]);
        wait_clk(500);
        check("stall_hold_end", tx, exp[i]);
        #2 stall = 1'b0;
        wait_clk(160);
      end else if (i != NBITS - 1) begin
        wait_clk(160);
      end
    end
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (bus.tx_done_tick !== 1'b1 && k < 400) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_done_seen"}, bus.tx_done_tick, 1'b1);
    check({tag, "_busy_at_done"}, bus.tx_busy, 1'b0);
  endtask

  initial begin
    bus.tx_start = 1'b0;
    bus.din      = 8'h00;

    // Reset state, during and after reset.
    wait_clk(3);
    check("rst_tx", tx, 1'b1);
    check("rst_busy", bus.tx_busy, 1'b0);
    check("rst_done", bus.tx_done_tick, 1'b0);
    rst_n = 1'b1;
    wait_clk(20);
    check("idle_tx", tx, 1'b1);
    check("idle_busy", bus.tx_busy, 1'b0);

    // Basic frame.
    clear_mon();
    start_frame(8'hA5);
    capture(-1, -1, F_A5, fr);
    check("basic_frame", fr, F_A5);
    wait_done("basic");
    wait_clk(5);
    check("basic_done_cnt", done_cnt, 1);
    check("basic_done_width", done_run_max, 1);

    // Busy rejection: request with 0xFF during a data bit must be dropped.
    clear_mon();
    start_frame(8'hA5);
    capture(3, -1, F_A5, fr);
    check("reject_frame", fr, F_A5);
    wait_done("reject");
    wait_clk(400);
    check("reject_done_cnt", done_cnt, 1);
    check("reject_tx_idle", tx, 1'b1);
    check("reject_busy_idle", bus.tx_busy, 1'b0);

    // Back-to-back with tx_start held high.
    clear_mon();
    @(negedge clk);
    bus.din      = 8'h00;
    bus.tx_start = 1'b1;
    @(negedge clk);
    check("b2b_first_edge", tx, 1'b0);
    bus.din = 8'h55;
    capture(-1, -1, F_00, fr);
    check("b2b_frame0", fr, F_00);
    wait_done("b2b0");
    check("b2b_done_clk_tx", tx, 1'b1);
    @(negedge clk);
    check("b2b_gap_tx", tx, 1'b1);
    check("b2b_gap_busy", bus.tx_busy, 1'b0);
    @(negedge clk);
    check("b2b_fall_tx", tx, 1'b0);
    check("b2b_fall_busy", bus.tx_busy, 1'b1);
    bus.tx_start = 1'b0;
    capture(-1, -1, F_55, fr);
    check("b2b_frame1", fr, F_55);
    wait_done("b2b1");
    wait_clk(5);
    check("b2b_done_cnt", done_cnt, 2);
    check("b2b_done_width", done_run_max, 1);

    // Reset during the start bit, where tx is low: tx must rise before any edge.
    clear_mon();
    start_frame(8'h3C);
    wait_clk(40);
    #1 rst_n = 1'b0;
    #1;
    check("rst_start_tx", tx, 1'b1);
    check("rst_start_busy", bus.tx_busy, 1'b0);
    wait_clk(3);
    rst_n = 1'b1;

    // Reset during bit 3 of 0x3C, then a clean 0xC3 frame.
    start_frame(8'h3C);
    wait_clk(80 + 3 * 160);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_tx", tx, 1'b1);
    check("rst_mid_busy", bus.tx_busy, 1'b0);
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(400);
    check("rst_mid_no_done", done_cnt, 0);
    check("rst_mid_tx_idle", tx, 1'b1);
    start_frame(8'hC3);
    capture(-1, -1, F_C3, fr);
    check("post_rst_frame", fr, F_C3);
    wait_done("post_rst");

    // Tick stall during data bit 3.
    clear_mon();
    start_frame(8'h5A);
    capture(-1, 4, F_5A, fr);
    check("stall_frame", fr, F_5A);
    wait_done("stall");
    wait_clk(5);
    check("stall_done_cnt", done_cnt, 1);

`ifdef UART_TX_PARITY_EN
    // 0x07 has three ones, so the even parity bit is 1.
    clear_mon();
    start_frame(8'h07);
    capture(-1, -1, F_07, fr);
    check("parity_frame_07", fr, F_07);
    wait_done("parity07");
`endif

    wait_clk(10);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
